// File: rtl/dsp_seq_core_if.sv
// dsp_seq_core_if: control handshake and memory-bank ports of dsp_seq_core
interface dsp_seq_core_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              start;
    logic [ADDR_W-1:0] start_pc;
    logic              busy;
    logic              done;
    logic [31:0]       cycle_cnt;
    logic [ADDR_W-1:0] read_addr_i;
    logic [31:0]       read_data_i;
    logic [ADDR_W-1:0] read_addr_1;
    logic [DATA_W-1:0] read_data_1;
    logic [ADDR_W-1:0] write_addr_2;
    logic [DATA_W-1:0] write_data_2;
    logic              write_en_2;

    modport slave (
        input  start, start_pc, read_data_i, read_data_1,
        output busy, done, cycle_cnt, read_addr_i, read_addr_1,
               write_addr_2, write_data_2, write_en_2
    );

    modport master (
        output start, start_pc, read_data_i, read_data_1,
        input  busy, done, cycle_cnt, read_addr_i, read_addr_1,
               write_addr_2, write_data_2, write_en_2
    );
endinterface

// File: rtl/dsp_seq_core.sv
// dsp_seq_core: sequencing DSP core with register file, signed MAC and a zero-overhead loop
module dsp_seq_core #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int NREG   = 16,
    parameter int ACC_W  = 40
) (
    input  logic          clk,
    input  logic          rst,
    dsp_seq_core_if.slave bus
);
    localparam int RI_W = $clog2(NREG);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_MEM   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_MAC  = 4'h4;
    localparam logic [3:0] OP_CLR  = 4'h5;
    localparam logic [3:0] OP_MOV  = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_LDI  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_BNZ  = 4'hB;
    localparam logic [3:0] OP_LOOP = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] loop_start_q, loop_start_d;
    logic [ADDR_W-1:0] loop_end_q, loop_end_d;
    logic [DATA_W-1:0] loop_cnt_q, loop_cnt_d;
    logic              loop_act_q, loop_act_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [31:0]       cyc_q, cyc_d;
    logic [RI_W-1:0]   ld_rd_q, ld_rd_d;
    logic [DATA_W-1:0] rf_q [NREG];
    logic [DATA_W-1:0] rf_d [NREG];

    logic [3:0]                 op;
    logic [RI_W-1:0]            rd, rs1, rs2, wr_idx;
    logic [15:0]                imm;
    logic [DATA_W-1:0]          rd_v, rs1_v, rs2_v, imm_v, mov_v, wr_v;
    logic [ADDR_W-1:0]          imm_a, ea;
    logic signed [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]           acc_sh;
    logic                       sat_hi, sat_lo, is_exec, wr_en, no_lb;

    assign op    = bus.read_data_i[31:28];
    assign rd    = bus.read_data_i[24 +: RI_W];
    assign rs1   = bus.read_data_i[20 +: RI_W];
    assign rs2   = bus.read_data_i[16 +: RI_W];
    assign imm   = bus.read_data_i[15:0];
    assign rd_v  = rf_q[rd];
    assign rs1_v = rf_q[rs1];
    assign rs2_v = rf_q[rs2];
    assign imm_v = DATA_W'($signed(imm));
    assign imm_a = ADDR_W'(imm);
    assign ea    = ADDR_W'(rs1_v) + imm_a;
    assign prod  = $signed(rs1_v) * $signed(rs2_v);

    // MOVACC: arithmetic shift then clamp to the signed DATA_W range
    assign acc_sh = $signed(acc_q) >>> imm[4:0];
    assign sat_hi = ~acc_sh[ACC_W-1] & (|acc_sh[ACC_W-2:DATA_W-1]);
    assign sat_lo = acc_sh[ACC_W-1] & ~(&acc_sh[ACC_W-2:DATA_W-1]);
    assign mov_v  = sat_hi ? {1'b0, {(DATA_W-1){1'b1}}} :
                    sat_lo ? {1'b1, {(DATA_W-1){1'b0}}} : acc_sh[DATA_W-1:0];

    assign is_exec          = state_q == S_EXEC;
    assign bus.busy         = state_q != S_IDLE;
    assign bus.done         = state_q == S_DONE;
    assign bus.cycle_cnt    = cyc_q;
    assign bus.read_addr_i  = pc_q;
    assign bus.read_addr_1  = (is_exec && op == OP_LD) ? ea : '0;
    assign bus.write_en_2   = is_exec && op == OP_ST;
    assign bus.write_addr_2 = bus.write_en_2 ? ea : '0;
    assign bus.write_data_2 = bus.write_en_2 ? rd_v : '0;

    // sequencer, execute stage, loop-back and register write-back
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        acc_d        = acc_q;
        cyc_d        = (state_q != S_IDLE) ? cyc_q + 32'd1 : cyc_q;
        loop_start_d = loop_start_q;
        loop_end_d   = loop_end_q;
        loop_cnt_d   = loop_cnt_q;
        loop_act_d   = loop_act_q;
        ld_rd_d      = ld_rd_q;
        rf_d         = rf_q;
        wr_en        = 1'b0;
        wr_idx       = rd;
        wr_v         = '0;
        no_lb        = 1'b0;
        case (state_q)
            S_IDLE: if (bus.start) begin
                state_d = S_FETCH;
                pc_d    = bus.start_pc;
                cyc_d   = '0;
            end
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                state_d = (op == OP_HALT) ? S_DONE : (op == OP_LD) ? S_MEM : S_FETCH;
                pc_d    = pc_q + ADDR_W'(1);
                case (op)
                    OP_ADD: begin wr_en = 1'b1; wr_v = rs1_v + rs2_v; end
                    OP_SUB: begin wr_en = 1'b1; wr_v = rs1_v - rs2_v; end
                    OP_MUL: begin wr_en = 1'b1; wr_v = prod[DATA_W-1:0]; end
                    OP_MAC: acc_d = acc_q + ACC_W'(prod);
                    OP_CLR: acc_d = '0;
                    OP_MOV: begin wr_en = 1'b1; wr_v = mov_v; end
                    OP_LD:  ld_rd_d = rd;
                    OP_LDI: begin wr_en = 1'b1; wr_v = imm_v; end
                    OP_JMP: begin pc_d = imm_a; no_lb = 1'b1; end
                    OP_BNZ: if (rd_v != '0) begin pc_d = imm_a; no_lb = 1'b1; end
                    OP_LOOP: begin
                        no_lb        = 1'b1;
                        loop_cnt_d   = rs1_v;
                        loop_start_d = pc_q + ADDR_W'(1);
                        loop_end_d   = imm_a;
                        loop_act_d   = rs1_v != '0;
                        if (rs1_v == '0) pc_d = imm_a + ADDR_W'(1);
                    end
                    OP_HALT: begin pc_d = pc_q; no_lb = 1'b1; end
                    default: ;
                endcase
                if (!no_lb && loop_act_q && pc_q == loop_end_q) begin
                    loop_cnt_d = loop_cnt_q - DATA_W'(1);
                    loop_act_d = loop_cnt_q > DATA_W'(1);
                    if (loop_cnt_q > DATA_W'(1)) pc_d = loop_start_q;
                end
            end
            S_MEM: begin
                state_d = S_FETCH;
                wr_en   = 1'b1;
                wr_idx  = ld_rd_q;
                wr_v    = bus.read_data_1;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (wr_en && wr_idx != '0) rf_d[wr_idx] = wr_v;
    end

    // state registers; reset also drops any in-flight instruction
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            acc_q        <= '0;
            cyc_q        <= '0;
            loop_start_q <= '0;
            loop_end_q   <= '0;
            loop_cnt_q   <= '0;
            loop_act_q   <= 1'b0;
            ld_rd_q      <= '0;
            rf_q         <= '{default: '0};
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            acc_q        <= acc_d;
            cyc_q        <= cyc_d;
            loop_start_q <= loop_start_d;
            loop_end_q   <= loop_end_d;
            loop_cnt_q   <= loop_cnt_d;
            loop_act_q   <= loop_act_d;
            ld_rd_q      <= ld_rd_d;
            rf_q         <= rf_d;
        end
    end
endmodule

// File: tb/tb_dsp_seq_core.sv
// tb_dsp_seq_core: directed vector and program checks for dsp_seq_core
module tb_dsp_seq_core;
    localparam int DW = 16;
    localparam int AW = 16;

    localparam logic [3:0] ADD = 4'h1, SUB = 4'h2, MUL = 4'h3, MAC = 4'h4, CLR = 4'h5,
                           MOV = 4'h6, LD = 4'h7, ST = 4'h8, LDI = 4'h9, JMP = 4'hA,
                           BNZ = 4'hB, LOOP = 4'hC, RSV = 4'hD, HALT = 4'hF;

    typedef struct {
        logic [3:0]    op;
        logic [3:0]    rd;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dsp_seq_core_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    dsp_seq_core #(.DATA_W(DW), .ADDR_W(AW), .NREG(16), .ACC_W(40)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [31:0]   imem  [256];
    logic [DW-1:0] bank1 [256];
    logic [DW-1:0] bank2 [256];
    int wr_cnt = 0;
    int checks = 0;
    int errors = 0;
    vec_t vt [12];

    always @(posedge clk) begin
        bus.read_data_i <= imem[bus.read_addr_i[7:0]];
        bus.read_data_1 <= bank1[bus.read_addr_1[7:0]];
        if (bus.write_en_2) begin
            bank2[bus.write_addr_2[7:0]] <= bus.write_data_2;
            wr_cnt <= wr_cnt + 1;
        end
    end

    function automatic logic [31:0] ins(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2,
                                        input logic [15:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run(input logic [15:0] spc, input int lat, input string nm);
        int n;
        n = 0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.start_pc = spc;
        @(negedge clk);
        bus.start = 1'b0;
        chk({nm, " busy"}, 32'(bus.busy), 32'd1);
        chk({nm, " pc0"}, 32'(bus.read_addr_i), 32'(spc));
        while (bus.done !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, n, lat);
        chk({nm, " cnt_at_done"}, bus.cycle_cnt, lat);
        @(negedge clk);
        chk({nm, " done_pulse"}, 32'(bus.done), 32'd0);
        chk({nm, " idle"}, 32'(bus.busy), 32'd0);
        chk({nm, " cnt_hold"}, bus.cycle_cnt, lat + 1);
    endtask

    initial begin
        int w0, n;
        logic [7:0] sa;
        bus.start    = 1'b1;
        bus.start_pc = 16'h1234;
        bank1[8'h20] = 16'h0007;
        bank1[8'h22] = 16'h1234;
        vt[0]  = '{ADD, 4'd3,  16'h0005, 16'hFFFD, 16'h0002};
        vt[1]  = '{ADD, 4'd3,  16'h7FFF, 16'h0001, 16'h8000};
        vt[2]  = '{ADD, 4'd3,  16'hFFFF, 16'h0001, 16'h0000};
        vt[3]  = '{SUB, 4'd3,  16'h0005, 16'hFFFD, 16'h0008};
        vt[4]  = '{SUB, 4'd3,  16'h0000, 16'h0001, 16'hFFFF};
        vt[5]  = '{SUB, 4'd3,  16'h8000, 16'h0001, 16'h7FFF};
        vt[6]  = '{MUL, 4'd3,  16'h0005, 16'hFFFD, 16'hFFF1};
        vt[7]  = '{MUL, 4'd3,  16'h0100, 16'h0100, 16'h0000};
        vt[8]  = '{MUL, 4'd3,  16'hFFFF, 16'hFFFF, 16'h0001};
        vt[9]  = '{MUL, 4'd3,  16'h0123, 16'h0010, 16'h1230};
        vt[10] = '{ADD, 4'd0,  16'h0005, 16'h0006, 16'h0000};
        vt[11] = '{ADD, 4'd15, 16'h0002, 16'h0003, 16'h0005};

        repeat (2) @(negedge clk);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst we2", 32'(bus.write_en_2), 32'd0);
        chk("rst addr_i", 32'(bus.read_addr_i), 32'd0);
        chk("rst addr_1", 32'(bus.read_addr_1), 32'd0);
        chk("rst addr_2", 32'(bus.write_addr_2), 32'd0);
        chk("rst data_2", 32'(bus.write_data_2), 32'd0);
        chk("rst cnt", bus.cycle_cnt, 32'd0);
        bus.start = 1'b0;
        rst = 1'b1;

        imem[0] = ins(LDI, 1, 0, 0, 16'h0005);
        imem[1] = ins(LDI, 2, 0, 0, 16'hFFFD);
        imem[2] = ins(ADD, 3, 1, 2, 0);
        imem[3] = ins(SUB, 4, 1, 2, 0);
        imem[4] = ins(MUL, 5, 1, 2, 0);
        imem[5] = ins(ST, 3, 0, 0, 16'h10);
        imem[6] = ins(ST, 4, 0, 0, 16'h11);
        imem[7] = ins(ST, 5, 0, 0, 16'h12);
        imem[8] = ins(HALT, 0, 0, 0, 0);
        run(16'h0000, 18, "arith");
        chk("arith add", 32'(bank2[8'h10]), 32'h0002);
        chk("arith sub", 32'(bank2[8'h11]), 32'h0008);
        chk("arith mul", 32'(bank2[8'h12]), 32'hFFF1);

        for (int i = 0; i < 12; i++) begin
            sa = 8'h60 + 8'(i);
            imem[0] = ins(LDI, 1, 0, 0, vt[i].a);
            imem[1] = ins(LDI, 2, 0, 0, vt[i].b);
            imem[2] = ins(vt[i].op, vt[i].rd, 1, 2, 0);
            imem[3] = ins(ST, vt[i].rd, 0, 0, {8'h00, sa});
            imem[4] = ins(HALT, 0, 0, 0, 0);
            run(16'h0000, 10, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d result", i), 32'(bank2[sa]), 32'(vt[i].exp));
        end

        imem[0] = ins(LDI, 1, 0, 0, 16'h7FFF);
        imem[1] = ins(CLR, 0, 0, 0, 0);
        for (int i = 2; i < 6; i++) imem[i] = ins(MAC, 0, 1, 1, 0);
        imem[6]  = ins(MOV, 2, 0, 0, 0);
        imem[7]  = ins(ST, 2, 0, 0, 16'h20);
        imem[8]  = ins(LDI, 3, 0, 0, 16'hFFFF);
        imem[9]  = ins(CLR, 0, 0, 0, 0);
        imem[10] = ins(MAC, 0, 1, 3, 0);
        imem[11] = ins(MOV, 4, 0, 0, 16'd31);
        imem[12] = ins(ST, 4, 0, 0, 16'h21);
        imem[13] = ins(MOV, 5, 0, 0, 0);
        imem[14] = ins(ST, 5, 0, 0, 16'h22);
        imem[15] = ins(MAC, 0, 1, 3, 0);
        imem[16] = ins(MAC, 0, 1, 3, 0);
        imem[17] = ins(MOV, 6, 0, 0, 0);
        imem[18] = ins(ST, 6, 0, 0, 16'h23);
        imem[19] = ins(MOV, 7, 0, 0, 16'd2);
        imem[20] = ins(ST, 7, 0, 0, 16'h24);
        imem[21] = ins(HALT, 0, 0, 0, 0);
        run(16'h0000, 44, "mac");
        chk("mac sat_pos", 32'(bank2[8'h20]), 32'h7FFF);
        chk("mac shift31", 32'(bank2[8'h21]), 32'hFFFF);
        chk("mac plain_neg", 32'(bank2[8'h22]), 32'h8001);
        chk("mac sat_neg", 32'(bank2[8'h23]), 32'h8000);
        chk("mac shift2", 32'(bank2[8'h24]), 32'hA000);

        imem[0]  = ins(LDI, 1, 0, 0, 16'd3);
        imem[1]  = ins(LDI, 2, 0, 0, 16'd0);
        imem[2]  = ins(LDI, 4, 0, 0, 16'd1);
        imem[3]  = ins(LOOP, 0, 1, 0, 16'd5);
        imem[4]  = ins(ADD, 2, 2, 4, 0);
        imem[5]  = ins(RSV, 7, 7, 7, 16'hFFFF);
        imem[6]  = ins(ST, 2, 0, 0, 16'h30);
        imem[7]  = ins(LDI, 1, 0, 0, 16'd0);
        imem[8]  = ins(LOOP, 0, 1, 0, 16'd10);
        imem[9]  = ins(ADD, 2, 2, 4, 0);
        imem[10] = ins(ADD, 2, 2, 4, 0);
        imem[11] = ins(ST, 2, 0, 0, 16'h31);
        imem[12] = ins(JMP, 0, 0, 0, 16'd14);
        imem[13] = ins(ST, 4, 0, 0, 16'h32);
        imem[14] = ins(HALT, 0, 0, 0, 0);
        w0 = wr_cnt;
        run(16'h0000, 32, "loop");
        chk("loop body3", 32'(bank2[8'h30]), 32'd3);
        chk("loop skip", 32'(bank2[8'h31]), 32'd3);
        chk("loop writes", wr_cnt - w0, 32'd2);

        imem[8'h80] = ins(LDI, 2, 0, 0, 16'd1);
        imem[8'h81] = ins(LDI, 3, 0, 0, 16'd0);
        imem[8'h82] = ins(LD, 1, 0, 0, 16'h20);
        imem[8'h83] = ins(ADD, 3, 3, 2, 0);
        imem[8'h84] = ins(SUB, 1, 1, 2, 0);
        imem[8'h85] = ins(BNZ, 1, 0, 0, 16'h83);
        imem[8'h86] = ins(ST, 3, 0, 0, 16'h40);
        imem[8'h87] = ins(LD, 7, 2, 0, 16'h21);
        imem[8'h88] = ins(ST, 7, 2, 0, 16'h40);
        imem[8'h89] = ins(HALT, 0, 0, 0, 0);
        run(16'h0080, 58, "ldbnz");
        chk("ldbnz iters", 32'(bank2[8'h40]), 32'd7);
        chk("ldbnz ld_off", 32'(bank2[8'h41]), 32'h1234);

        imem[0] = ins(LDI, 1, 0, 0, 16'h0055);
        imem[1] = ins(ST, 1, 0, 0, 16'h50);
        imem[2] = ins(HALT, 0, 0, 0, 0);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.start_pc = 16'h0000;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort st_we", 32'(bus.write_en_2), 32'd1);
        chk("abort st_addr", 32'(bus.write_addr_2), 32'h50);
        chk("abort st_data", 32'(bus.write_data_2), 32'h55);
        rst = 1'b0;
        @(negedge clk);
        chk("abort we_low", 32'(bus.write_en_2), 32'd0);
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort cnt", bus.cycle_cnt, 32'd0);
        chk("abort pc", 32'(bus.read_addr_i), 32'd0);
        rst = 1'b1;

        imem[8'h10] = ins(ST, 1, 0, 0, 16'h51);
        imem[8'h11] = ins(LDI, 2, 0, 0, 16'h0066);
        imem[8'h12] = ins(ST, 2, 0, 0, 16'h52);
        imem[8'h13] = ins(HALT, 0, 0, 0, 0);
        run(16'h0010, 8, "rerun");
        chk("rerun reg_clr", 32'(bank2[8'h51]), 32'd0);
        chk("rerun store", 32'(bank2[8'h52]), 32'h66);

        @(negedge clk);
        bus.start    = 1'b1;
        bus.start_pc = 16'h0010;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.done !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("dstart latency", n, 32'd8);
        bus.start = 1'b1;
        @(negedge clk);
        chk("dstart ignored", 32'(bus.busy), 32'd0);
        bus.start = 1'b0;
        @(negedge clk);
        chk("dstart no_launch", 32'(bus.busy), 32'd0);
        chk("dstart cnt", bus.cycle_cnt, 32'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
